// File: rtl/bus_term_sync.sv
// Bus-cycle termination sequencer for the 68000 side: synchronises /DTACK, /BERR, /VPA and
// emits one-cycle SET/CLR strobes for the termination latch. Timeout option: BUS_TERM_TIMEOUT_EN.

module bus_term_sync_chain #(
    parameter int STAGES = 2
) (
    input  logic CLK,
    input  logic nRESET,
    input  logic d_i,
    output logic q_o
);
    logic [STAGES-1:0] sync_q;

    // Chain resets to the deasserted (high) level of the active-low bus signal
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) sync_q <= '1;
        else         sync_q <= {sync_q[STAGES-2:0], d_i};
    end

    assign q_o = sync_q[STAGES-1];
endmodule

module bus_term_sync #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic       START,
    input  logic       ABORT,
    input  logic       nDTACK_IN,
    input  logic       nBERR_IN,
    input  logic       nVPA_IN,
    output logic       TERM_SET,
    output logic       TERM_CLR,
    output logic [1:0] STATUS,
    output logic       BUSY
);
    localparam int NUM_IN = 3;
    localparam int I_BERR = 0, I_DTACK = 1, I_VPA = 2;

    localparam logic [1:0] ST_DTACK   = 2'b00;
    localparam logic [1:0] ST_VPA     = 2'b01;
    localparam logic [1:0] ST_BERR    = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_WAIT, S_TERM} state_e;

    if (SYNC_STAGES < 2 || SYNC_STAGES > 3 ||
        TIMEOUT_CYCLES < 4 || TIMEOUT_CYCLES > 65535) begin : g_param_err
        $error("bus_term_sync: parameter out of legal range");
    end

    logic [NUM_IN-1:0] n_raw, n_sync;
    assign n_raw = {nVPA_IN, nDTACK_IN, nBERR_IN};

    for (genvar i = 0; i < NUM_IN; i++) begin : g_sync
        bus_term_sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
            .CLK    (CLK),
            .nRESET (nRESET),
            .d_i    (n_raw[i]),
            .q_o    (n_sync[i])
        );
    end

    state_e     state_q, state_d;
    logic [1:0] cause_d;
    logic       term_set_q, term_set_d;
    logic       term_clr_q, term_clr_d;
    logic       busy_q, busy_d;
    logic [1:0] status_q, status_d;
    logic       timeout;

`ifdef BUS_TERM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign timeout = (cnt_q == CNT_MAX);

    // Counts only while a cycle is open; saturates so a late exit can never wrap it
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_IDLE && START && !ABORT)
            cnt_d = '0;
        else if ((state_q == S_ARM || state_q == S_WAIT) && cnt_q != CNT_MAX)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q    <= S_IDLE;
            term_set_q <= 1'b0;
            term_clr_q <= 1'b0;
            busy_q     <= 1'b0;
            status_q   <= ST_DTACK;
        end else begin
            state_q    <= state_d;
            term_set_q <= term_set_d;
            term_clr_q <= term_clr_d;
            busy_q     <= busy_d;
            status_q   <= status_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = status_q;
        unique case (state_q)
            S_IDLE: if (START) state_d = S_ARM;
            // Refuse to start watching until every input is released, so a stale
            // acknowledge left over from the previous cycle cannot end this one
            S_ARM: begin
                if (timeout) begin
                    state_d = S_TERM;
                    cause_d = ST_TIMEOUT;
                end else if (&n_sync) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!n_sync[I_BERR]) begin
                    state_d = S_TERM;
                    cause_d = ST_BERR;
                end else if (!n_sync[I_DTACK]) begin
                    state_d = S_TERM;
                    cause_d = ST_DTACK;
                end else if (!n_sync[I_VPA]) begin
                    state_d = S_TERM;
                    cause_d = ST_VPA;
                end else if (timeout) begin
                    state_d = S_TERM;
                    cause_d = ST_TIMEOUT;
                end
            end
            S_TERM: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (ABORT) state_d = S_IDLE;
    end

    // Outputs are registered from the next state, so each strobe lines up with its state
    always_comb begin
        term_set_d = (state_d == S_TERM);
        term_clr_d = ABORT || (state_q == S_IDLE && START);
        busy_d     = (state_d != S_IDLE);
        status_d   = (state_d == S_TERM && state_q != S_TERM) ? cause_d : status_q;
    end

    assign TERM_SET = term_set_q;
    assign TERM_CLR = term_clr_q;
    assign STATUS   = status_q;
    assign BUSY     = busy_q;
endmodule

// File: doc/bus_term_sync.md
# bus_term_sync

Bus-cycle termination stage for the 68000 side of the gateware. It synchronises the asynchronous active-low /DTACK, /BERR and /VPA bus inputs and sequences each bus cycle. It emits one-cycle SET and RESET strobes that drive the downstream set/reset termination latch, and reports which signal ended the cycle. It sits between the 68000 pins and that latch, directly upstream of it.

## Interface
Parameters:
- SYNC_STAGES, 2: synchroniser depth per bus input; legal 2..3.
- TIMEOUT_CYCLES, 1023: CLK cycles from START acceptance to forced timeout; legal 4..65535.

Ports:
- CLK  in  1  single system clock; all state on rising edge.
- nRESET  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- START  in  1  one-cycle pulse: bus cycle begun (/AS asserted by the bus master FSM).
- ABORT  in  1  one-cycle pulse: cancel current cycle.
- nDTACK_IN  in  1  async, active-low data transfer acknowledge.
- nBERR_IN  in  1  async, active-low bus error.
- nVPA_IN  in  1  async, active-low valid peripheral address.
- TERM_SET  out  1  one-cycle pulse, drives latch SET.
- TERM_CLR  out  1  one-cycle pulse, drives latch RESET.
- STATUS  out  2  termination cause: 00 DTACK, 01 VPA, 10 BERR, 11 TIMEOUT. Valid while TERM_SET=1; held until next termination.
- BUSY  out  1  high in ARM, WAIT, TERM.

## Operation
- Each n*_IN passes through a SYNC_STAGES flip-flop chain. Chains reset to 1 (deasserted). The FSM sees only the last stage.
- All outputs are registered. Reset values: TERM_SET=0, TERM_CLR=0, STATUS=00, BUSY=0, state=IDLE, counter=0.
- FSM states: IDLE, ARM, WAIT, TERM.
- IDLE: START=1 -> ARM. TERM_CLR=1 for exactly that transition cycle. Counter cleared to 0.
- ARM: waits until all three synced inputs are high, so no stale acknowledge from the previous cycle is taken. Then -> WAIT.
- WAIT: checks synced inputs with priority BERR > DTACK > VPA. The first one low loads STATUS (10/00/01) -> TERM.
- TERM: TERM_SET=1 for exactly one cycle -> IDLE. BUSY drops in the cycle after TERM.
- START while not IDLE: ignored, with no effect on state, counter or strobes.
- ABORT in any state: -> IDLE next edge, TERM_CLR=1 one cycle, no TERM_SET, STATUS unchanged.
- ABORT and START together in IDLE: ABORT wins. Block stays IDLE and pulses TERM_CLR once.
- ABORT in TERM: TERM_SET still pulses that cycle (already registered), plus TERM_CLR the following cycle.
- TERM_SET and TERM_CLR are never high in the same cycle.
- Async nRESET mid-cycle: all state returns to reset values immediately. No strobe is emitted on release.

## Timing
- Input latency: an input low before CLK edge k is visible to the FSM after edge k+SYNC_STAGES-1. The FSM enters TERM at edge k+SYNC_STAGES. With SYNC_STAGES=2, TERM_SET is high during the cycle after edge k+2.
- START to TERM_CLR: TERM_CLR is high in the cycle after the START edge.
- Minimum cycle from START acceptance to TERM_SET, inputs already high and DTACK asserted early: ARM 1 cycle + synchroniser + 1. That is 4 cycles at SYNC_STAGES=2.
- Input glitches shorter than one CLK period may be missed. Inputs must be held low until TERM_SET.

## Configuration
- Macro BUS_TERM_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) increments every cycle in ARM and WAIT.
  - When it equals TIMEOUT_CYCLES, the FSM goes -> TERM with STATUS=11.
  - A real termination detected in the same cycle as the timeout takes precedence.
  - The counter saturates and never wraps.
- Undefined:
  - No counter logic is built.
  - The block waits in ARM/WAIT indefinitely; only ABORT or nRESET exits.
  - STATUS=11 is never produced.

## Test plan
- Reset with SYNC_STAGES=2: hold nRESET low, then release. All outputs are 0 and BUSY=0. START pulse -> TERM_CLR=1 next cycle. nDTACK_IN low 3 cycles later -> TERM_SET one cycle, STATUS=00, BUSY=0 after.
- Priority: nBERR_IN and nDTACK_IN both driven low on the same edge during WAIT -> STATUS=10, exactly one TERM_SET pulse.
- Stale acknowledge: nDTACK_IN held low across START. The FSM stays in ARM with no TERM_SET. Drive nDTACK_IN high, then low -> single TERM_SET, STATUS=00.
- Timeout with BUS_TERM_TIMEOUT_EN and TIMEOUT_CYCLES=8: START with no input asserted -> TERM_SET with STATUS=11 exactly 9 cycles after the START edge. Without the macro: no TERM_SET within 100 cycles.
- ABORT in WAIT -> IDLE, TERM_CLR one cycle, no TERM_SET, STATUS unchanged. A START in the same cycle as ABORT in IDLE -> BUSY stays 0.
- Reset mid-cycle: assert nRESET in WAIT -> outputs 0 asynchronously. A subsequent full DTACK cycle completes normally.
